// File: rtl/note_key_pkg.sv
// Shared definitions for the note-key front end: note_out bit positions,
// the queued event format and the debounce counter width helper.
package note_key_pkg;

  localparam int NUM_KEYS       = 8;
  localparam int NOTE_VALID_BIT = 7;
  localparam int NOTE_PRESS_BIT = 6;
  localparam int NOTE_OVF_BIT   = 5;

  typedef struct packed {
    logic       press;
    logic [2:0] idx;
  } note_evt_t;

  // A debounce counter only has to reach DEB_TICKS-1.
  function automatic int cnt_width(input int deb_ticks);
    return (deb_ticks < 2) ? 1 : $clog2(deb_ticks);
  endfunction

endpackage

// File: rtl/note_evt_fifo.sv
// Register-based event queue. The head is read straight from the storage
// array, so a value pushed into an empty queue is visible the following cycle.
module note_evt_fifo
  import note_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] data,
  output logic [3:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] ONE     = 1;
  localparam logic [AW-1:0] PONE  = 1;

  note_evt_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Handshake: a pop on an empty queue is dropped; a push is taken when the
  // queue has room or a pop retires an entry in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PONE;
      if (do_pop)  rd_ptr <= rd_ptr + PONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= note_evt_t'(data);
  end

endmodule

// File: rtl/note_key_ctrl.sv
// Note-key front end: synchronise and debounce eight keys, queue press/release
// events and present the queue head to the polled PIO port.
module note_key_ctrl
  import note_key_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_in,
  input  logic       ack_in,
  output logic [7:0] note_out,
  output logic       overflow_o
);

  localparam int TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int CW = cnt_width(DEB_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;

  logic [7:0]    key_s1, key_s2;
  logic          ack_s1, ack_s2, ack_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] cnt    [NUM_KEYS];
  logic [CW-1:0] cnt_nx [NUM_KEYS];
  logic [7:0]    stable, stable_nx;
  logic [7:0]    pend, pend_nx;
  logic [7:0]    flip, clear;
  logic          overflow, overflow_nx, lost;
  logic [2:0]    sel;
  logic          push, pop;
  note_evt_t     push_evt, head_evt;
  logic [3:0]    head;
  logic          empty, full;

  assign tick = (tick_cnt == TICK_LAST);
  assign pop  = ack_s2 & ~ack_d & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1   <= '0;
      key_s2   <= '0;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_d    <= 1'b0;
      tick_cnt <= '0;
      stable   <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      key_s1   <= key_in;
      key_s2   <= key_s1;
      ack_s1   <= ack_in;
      ack_s2   <= ack_s1;
      ack_d    <= ack_s2;
      tick_cnt <= tick ? '0 : tick_cnt + TICK_ONE;
      stable   <= stable_nx;
      pend     <= pend_nx;
      overflow <= overflow_nx;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= cnt_nx[i];
    end
  end

  always_comb begin
    stable_nx = stable;
    flip      = '0;
    cnt_nx    = cnt;
    if (tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_s2[i] == stable[i]) begin
          cnt_nx[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_nx[i] = ~stable[i];
          cnt_nx[i]    = '0;
          flip[i]      = 1'b1;
        end else begin
          cnt_nx[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Scheduler reads the pre-flip stable value, so an event pushed in the same
  // cycle as a new flip is not lost; only an un-drained pend bit overflows.
  always_comb begin
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) sel = 3'(i);
    end
    push           = (|pend) & (~full | pop);
    push_evt.press = stable[sel];
    push_evt.idx   = sel;
    clear          = push ? (8'b1 << sel) : 8'b0;
    pend_nx        = (pend & ~clear) | flip;
    lost           = |(flip & pend & ~clear);
    overflow_nx    = overflow;
    if (pop)  overflow_nx = 1'b0;
    if (lost) overflow_nx = 1'b1;
  end

  note_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (push_evt),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  assign head_evt = note_evt_t'(head);

  always_comb begin
    note_out                 = '0;
    note_out[NOTE_VALID_BIT] = ~empty;
    note_out[NOTE_OVF_BIT]   = overflow;
    if (!empty) begin
      note_out[NOTE_PRESS_BIT] = head_evt.press;
      note_out[2:0]            = head_evt.idx;
    end
  end

  assign overflow_o = overflow;

endmodule

// File: tb/tb_note_key_ctrl.sv
// Directed bench for note_key_ctrl with TICK_DIV=4, DEB_TICKS=3: press,
// bounce, simultaneous keys, full queue with overflow, collision and reset.
module tb_note_key_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       ack_in;
  logic [7:0] note_out;
  logic       overflow_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  note_key_ctrl #(.TICK_DIV(4), .DEB_TICKS(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .ack_in     (ack_in),
    .note_out   (note_out),
    .overflow_o (overflow_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int lat);
    lat = 0;
    while (!note_out[7] && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!note_out[7]) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_ack();
    ack_in = 1'b1;
    cycles(3);
    ack_in = 1'b0;
    cycles(3);
  endtask

  task automatic drain(input string tag);
    int lat;
    wait_valid(tag, 40, lat);
    while (exp_q.size() > 0) begin
      check(tag, {24'd0, note_out}, {24'd0, exp_q.pop_front()});
      pulse_ack();
    end
    check({tag, "_empty"}, {24'd0, note_out}, 32'h00);
  endtask

  initial begin
    int lat;
    int viol;
    reset  = 1'b1;
    key_in = '0;
    ack_in = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_note", {24'd0, note_out}, 32'h00);
    check("reset_ovf", {31'd0, overflow_o}, 32'd0);

    // clean press on key 5, ack, then release
    cycles(5);
    key_in[5] = 1'b1;
    wait_valid("press5", 40, lat);
    check("press5_note", {24'd0, note_out}, 32'hC5);
    check("press5_lat_min", {31'd0, lat >= 11}, 32'd1);
    check("press5_lat_max", {31'd0, lat <= 15}, 32'd1);
    ack_in = 1'b1;
    cycles(2);
    check("pop_not_early", {24'd0, note_out}, 32'hC5);
    cycles(1);
    check("pop_at_n2", {24'd0, note_out}, 32'h00);
    ack_in = 1'b0;
    cycles(3);
    key_in[5] = 1'b0;
    wait_valid("release5", 40, lat);
    check("release5_note", {24'd0, note_out}, 32'h85);
    pulse_ack();
    check("release5_empty", {24'd0, note_out}, 32'h00);

    // bounce on key 2: high runs are shorter than one tick period
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) key_in[2] = ~key_in[2];
      @(negedge clk);
      if (note_out != 8'h00) viol++;
    end
    key_in[2] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (note_out != 8'h00) viol++;
    end
    check("bounce_no_event", viol, 32'd0);
    check("bounce_note", {24'd0, note_out}, 32'h00);

    // simultaneous keys 0, 3, 7: lowest index first
    key_in = 8'h89;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC7);
    drain("simul_press");
    key_in = 8'h00;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h87);
    drain("simul_release");

    // full queue: keys 0..5 pressed, 4 queued and 4,5 pending
    key_in = 8'h3F;
    cycles(20);
    check("full_head", {24'd0, note_out}, 32'hC0);
    check("full_ovf_clear", {31'd0, overflow_o}, 32'd0);
    key_in = 8'h3E;
    cycles(20);
    check("full_rel0_held", {24'd0, note_out}, 32'hC0);
    key_in = 8'h3F;
    cycles(20);
    check("ovf_note", {24'd0, note_out}, 32'hE0);
    check("ovf_led", {31'd0, overflow_o}, 32'd1);
    // this pop collides with the push of pending key 0
    pulse_ack();
    check("ovf_cleared", {31'd0, overflow_o}, 32'd0);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'hC5);
    drain("collide");

    // reset mid-tick with queued and pending events; key 6 held through it
    key_in = 8'h00;
    cycles(20);
    check("pre_reset_head", {24'd0, note_out}, 32'h80);
    #2;
    reset  = 1'b1;
    key_in = 8'h40;
    #1;
    check("async_reset_note", {24'd0, note_out}, 32'h00);
    check("async_reset_ovf", {31'd0, overflow_o}, 32'd0);
    cycles(3);
    reset = 1'b0;
    wait_valid("held6", 40, lat);
    check("held6_note", {24'd0, note_out}, 32'hC6);
    pulse_ack();
    check("held6_empty", {24'd0, note_out}, 32'h00);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
